// File: rtl/adc_frontend.sv
// adc_frontend: ADC word conditioning, DC removal and windowed peak.
// Define ADC_FE_DERAND_EN to build the output-randomizer removal path.
module adc_frontend #(
  parameter int ADC_BITS  = 14,
  parameter int DC_SHIFT  = 12,
  parameter int ACQ_SHIFT = 6,
  parameter int HOLD_LOG2 = 16
) (
  input  logic                       adc_clk,
  input  logic                       reset_n,
  input  logic [ADC_BITS-1:0]        adc_raw,
  input  logic                       adc_of_raw,
  input  logic                       cfg_wr,
  input  logic [3:0]                 cfg_data,
  output logic signed [ADC_BITS-1:0] adc_data,
  output logic                       adc_ovfl,
  output logic [ADC_BITS-2:0]        peak_A,
  output logic                       peak_strobe,
  output logic [1:0]                 dc_state
);

  localparam int FW = ADC_BITS + DC_SHIFT;

  typedef enum logic [1:0] {
    ACQ   = 2'd0,
    TRACK = 2'd1,
    HOLD  = 2'd2
  } st_t;

  st_t                       st;
  logic [11:0]               acq_cnt;
  logic [ADC_BITS-1:0]       raw_q;
  logic                      of1;
  logic                      of2;
  logic signed [ADC_BITS-1:0] x_q;
  logic [3:0]                cfg;
  logic                      cfg_new;
  logic signed [FW-1:0]      dc_fp;
  logic [HOLD_LOG2-1:0]      win;
  logic [ADC_BITS-2:0]       run_max;

  assign dc_state = st;

  // S2: undo the randomizer, then offset-binary to two's complement
  logic [ADC_BITS-1:0] dr;
`ifdef ADC_FE_DERAND_EN
  always_comb begin
    dr = raw_q;
    if (cfg[3])
      dr[ADC_BITS-1:1] = raw_q[ADC_BITS-1:1]
                       ^ {(ADC_BITS-1){raw_q[0]}};
  end
`else
  logic cfg_unused;
  assign cfg_unused = cfg[3];
  assign dr = raw_q;
`endif

  logic signed [ADC_BITS-1:0] x_n;
  assign x_n = {~dr[ADC_BITS-1], dr[ADC_BITS-2:0]};

  // S3: subtract floor(dc) with saturation
  logic signed [ADC_BITS-1:0] dc;
  logic signed [ADC_BITS:0]   dc_sub;
  logic signed [ADC_BITS:0]   diff;
  logic                       sat;
  logic signed [ADC_BITS-1:0] y;

  assign dc     = dc_fp[FW-1:DC_SHIFT];
  assign dc_sub = cfg[0] ? {dc[ADC_BITS-1], dc} : '0;
  assign diff   = {x_q[ADC_BITS-1], x_q} - dc_sub;

  always_comb begin
    sat = diff[ADC_BITS] ^ diff[ADC_BITS-1];
    y   = diff[ADC_BITS-1:0];
    if (sat)
      y = {diff[ADC_BITS], {(ADC_BITS-1){~diff[ADC_BITS]}}};
  end

  // estimator step, arithmetic shift gives floor
  logic signed [FW:0]   err;
  logic signed [FW-1:0] step;

  assign err  = {x_q[ADC_BITS-1], x_q, {DC_SHIFT{1'b0}}}
              - {dc_fp[FW-1], dc_fp};
  assign step = (st == ACQ) ? FW'(err >>> ACQ_SHIFT)
                            : FW'(err >>> DC_SHIFT);

  // |adc_data| with the most negative code pinned to full scale
  logic [ADC_BITS-2:0] mag;
  logic [ADC_BITS-2:0] mx;

  always_comb begin
    mag = adc_data[ADC_BITS-2:0];
    if (adc_data[ADC_BITS-1]) begin
      if (adc_data[ADC_BITS-2:0] == '0)
        mag = '1;
      else
        mag = ~adc_data[ADC_BITS-2:0] + (ADC_BITS-1)'(1);
    end
    mx = (mag > run_max) ? mag : run_max;
  end

  always_ff @(posedge adc_clk) begin
    if (!reset_n) begin
      raw_q    <= '0;
      of1      <= 1'b0;
      x_q      <= '0;
      of2      <= 1'b0;
      adc_data <= '0;
      adc_ovfl <= 1'b0;
      dc_fp    <= '0;
      cfg      <= 4'b0001;
      cfg_new  <= 1'b0;
    end else begin
      raw_q    <= adc_raw;
      of1      <= adc_of_raw;
      x_q      <= x_n;
      of2      <= of1;
      adc_data <= y;
      adc_ovfl <= of2 | sat;
      if (st != HOLD)
        dc_fp <= dc_fp + step;
      if (cfg_wr)
        cfg <= cfg_data;
      cfg_new <= cfg_wr;
    end
  end

  // restart acts once per write; freeze is a level
  always_ff @(posedge adc_clk) begin
    if (!reset_n) begin
      st      <= ACQ;
      acq_cnt <= '0;
    end else if (cfg[1]) begin
      st <= HOLD;
    end else if (cfg_new && cfg[2]) begin
      st      <= ACQ;
      acq_cnt <= '0;
    end else begin
      case (st)
        ACQ: begin
          acq_cnt <= acq_cnt + 12'd1;
          if (&acq_cnt)
            st <= TRACK;
        end
        HOLD:    st <= TRACK;
        default: st <= st;
      endcase
    end
  end

  always_ff @(posedge adc_clk) begin
    if (!reset_n) begin
      win         <= '0;
      run_max     <= '0;
      peak_A      <= '0;
      peak_strobe <= 1'b0;
    end else begin
      win <= win + HOLD_LOG2'(1);
      if (&win) begin
        peak_A      <= mx;
        peak_strobe <= 1'b1;
        run_max     <= '0;
      end else begin
        peak_strobe <= 1'b0;
        run_max     <= mx;
      end
    end
  end

endmodule

// File: tb/tb_adc_frontend.sv
// tb_adc_frontend: directed plus random stimulus for adc_frontend
// against a sample-level arithmetic reference model.
module tb_adc_frontend;

  localparam int AB = 14;
  localparam int DS = 12;
  localparam int AS = 6;
  localparam int HL = 4;

  logic                 adc_clk = 1'b0;
  logic                 reset_n = 1'b0;
  logic [AB-1:0]        adc_raw = '0;
  logic                 adc_of_raw = 1'b0;
  logic                 cfg_wr = 1'b0;
  logic [3:0]           cfg_data = '0;
  logic signed [AB-1:0] adc_data;
  logic                 adc_ovfl;
  logic [AB-2:0]        peak_A;
  logic                 peak_strobe;
  logic [1:0]           dc_state;

  adc_frontend #(
    .ADC_BITS (AB),
    .DC_SHIFT (DS),
    .ACQ_SHIFT(AS),
    .HOLD_LOG2(HL)
  ) dut (
    .adc_clk    (adc_clk),
    .reset_n    (reset_n),
    .adc_raw    (adc_raw),
    .adc_of_raw (adc_of_raw),
    .cfg_wr     (cfg_wr),
    .cfg_data   (cfg_data),
    .adc_data   (adc_data),
    .adc_ovfl   (adc_ovfl),
    .peak_A     (peak_A),
    .peak_strobe(peak_strobe),
    .dc_state   (dc_state)
  );

  always #5 adc_clk = ~adc_clk;

  int errors = 0;
  int checks = 0;

  // reference model state, one value per pipeline position
  int       m_s1, m_s1of, m_x, m_of2, m_out, m_ovfl;
  int       m_state, m_acq, m_win, m_run, m_peak, m_strobe;
  logic [3:0] m_cfg;
  bit       m_wr;
  longint   m_dc;

  int cyc = 0;
  int last_sc = -1;
  bit saw_peak = 0;

  task automatic chk(input string tag,
                     input logic signed [31:0] obs,
                     input logic signed [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic longint fdiv(input longint a, input int k);
    longint d, q;
    d = longint'(1) << k;
    q = a / d;
    if (a < 0 && q * d != a) q = q - 1;
    return q;
  endfunction

  function automatic int conv(input int raw, input bit der);
    int r;
    r = raw;
`ifdef ADC_FE_DERAND_EN
    if (der && (r % 2 == 1)) r = r ^ 'h3FFE;
`else
    if (der) r = raw;
`endif
    return r - 8192;
  endfunction

  function automatic int clamp(input int v);
    if (v > 8191) return 8191;
    if (v < -8192) return -8192;
    return v;
  endfunction

  task automatic model_edge();
    int dcv, y, c, a, k;
    if (!reset_n) begin
      m_s1 = 0; m_s1of = 0; m_x = 0; m_of2 = 0;
      m_out = 0; m_ovfl = 0; m_state = 0; m_acq = 0;
      m_win = 0; m_run = 0; m_peak = 0; m_strobe = 0;
      m_cfg = 4'b0001; m_wr = 0; m_dc = 0;
      return;
    end
    dcv = m_cfg[0] ? int'(fdiv(m_dc, DS)) : 0;
    y = m_x - dcv;
    c = clamp(y);
    a = (m_out < 0) ? -m_out : m_out;
    if (a > 8191) a = 8191;
    if (a > m_run) m_run = a;
    m_win = m_win + 1;
    if (m_win == (1 << HL)) begin
      m_win = 0; m_peak = m_run; m_run = 0; m_strobe = 1;
    end else begin
      m_strobe = 0;
    end
    m_out = c;
    m_ovfl = (m_of2 != 0 || c != y) ? 1 : 0;
    if (m_state != 2) begin
      k = (m_state == 0) ? AS : DS;
      m_dc = m_dc + fdiv(longint'(m_x) * 4096 - m_dc, k);
    end
    if (m_cfg[1]) m_state = 2;
    else if (m_wr && m_cfg[2]) begin
      m_state = 0; m_acq = 0;
    end else if (m_state == 2) m_state = 1;
    else if (m_state == 0) begin
      m_acq = m_acq + 1;
      if (m_acq == 4096) m_state = 1;
    end
    m_x = conv(m_s1, m_cfg[3]);
    m_of2 = m_s1of;
    m_s1 = int'(adc_raw);
    m_s1of = int'(adc_of_raw);
    if (cfg_wr) m_cfg = cfg_data;
    m_wr = cfg_wr;
  endtask

  task automatic tick(input int raw, input bit of,
                      input bit wr, input logic [3:0] d,
                      input bit rn);
    adc_raw = AB'(raw);
    adc_of_raw = of;
    cfg_wr = wr;
    cfg_data = d;
    reset_n = rn;
    @(posedge adc_clk);
    model_edge();
    cyc++;
    #1;
    chk("adc_data", adc_data, m_out);
    chk("adc_ovfl", adc_ovfl, m_ovfl);
    chk("dc_state", dc_state, m_state);
    chk("peak_A", peak_A, m_peak);
    chk("peak_strobe", peak_strobe, m_strobe);
    if (!rn) last_sc = -1;
    if (peak_strobe === 1'b1) begin
      if (peak_A == 13'd3000) saw_peak = 1;
      if (last_sc >= 0) chk("strobe_gap", cyc - last_sc, 1 << HL);
      last_sc = cyc;
    end
  endtask

  task automatic run(input int raw, input int n);
    for (int i = 0; i < n; i++) tick(raw, 0, 0, 4'h0, 1);
  endtask

  task automatic wcfg(input logic [3:0] d, input int raw);
    tick(raw, 0, 1, d, 1);
  endtask

  initial begin
    int v;
    // reset
    tick(0, 0, 0, 4'h0, 0);
    tick(0, 0, 0, 4'h0, 0);
    chk("rst_data", adc_data, 0);
    chk("rst_state", dc_state, 0);
    chk("rst_strobe", peak_strobe, 0);

    // constant 1000 codes: DC removal and ACQ->TRACK after 4096
    for (int i = 1; i <= 4095; i++) begin
      tick('h2000 + 1000, 0, 0, 4'h0, 1);
      if (i == 15) chk("pre_strobe", peak_strobe, 0);
      if (i == 16) chk("first_strobe", peak_strobe, 1);
    end
    chk("acq_4095", dc_state, 0);
    tick('h2000 + 1000, 0, 0, 4'h0, 1);
    chk("track_4096", dc_state, 1);
    v = int'(adc_data);
    chk("dc_settle", (v <= 1 && v >= -1) ? 1 : 0, 1);

    // settled dc at +1000, full-scale negative input saturates
    run(0, 3);
    chk("sat_data", adc_data, -8192);
    chk("sat_ovfl", adc_ovfl, 1);

    // dc off: straight conversion, overflow pin delayed 3
    wcfg(4'b0000, 'h2000);
    run('h2000, 3);
    tick('h3FFF, 1, 0, 4'h0, 1);
    tick('h3FFF, 1, 0, 4'h0, 1);
    chk("lat_data", adc_data, 0);
    tick('h3FFF, 1, 0, 4'h0, 1);
    chk("pos_full", adc_data, 8191);
    chk("pos_ovfl", adc_ovfl, 1);
    run(0, 3);
    chk("neg_full", adc_data, -8192);
    chk("neg_ovfl", adc_ovfl, 0);

    // freeze with restart: freeze wins, then unfreeze -> TRACK
    wcfg(4'b0111, 'h2100);
    chk("frz_pre", dc_state, 1);
    tick('h2100, 0, 0, 4'h0, 1);
    chk("frz_hold", dc_state, 2);
    run('h2100, 8);
    v = int'(adc_data);
    run('h2100, 6);
    chk("frz_dc_const", adc_data, v);
    wcfg(4'b0001, 'h2100);
    tick('h2100, 0, 0, 4'h0, 1);
    chk("unfrz_track", dc_state, 1);

    // restart alone returns to ACQ
    wcfg(4'b0101, 'h2100);
    tick('h2100, 0, 0, 4'h0, 1);
    chk("restart_acq", dc_state, 0);

    // peak over a ramp topping out at 3000
    wcfg(4'b0000, 'h2000);
    saw_peak = 0;
    for (int i = 0; i <= 48; i++) begin
      v = 3000 - ((i > 24) ? (i - 24) : (24 - i)) * 125;
      tick('h2000 + v, 0, 0, 4'h0, 1);
    end
    run('h2000, 40);
    chk("peak_3000", saw_peak, 1);

    // random traffic with occasional config writes
    for (int i = 0; i < 1500; i++) begin
      bit w;
      w = ($urandom_range(29) == 0);
      tick(int'($urandom_range(16383)), bit'($urandom_range(1)),
           w, 4'($urandom_range(15)), 1);
    end
    wcfg(4'b0001, 'h2000);
    run('h2000, 20);

`ifdef ADC_FE_DERAND_EN
    wcfg(4'b1000, 'h2000);
    run('h2001 ^ 'h3FFE, 3);
    chk("derand", adc_data, 1);
`endif

    // mid-stream reset clears all outputs on the next edge
    run('h3000, 5);
    tick('h3000, 1, 0, 4'h0, 0);
    chk("mrst_data", adc_data, 0);
    chk("mrst_ovfl", adc_ovfl, 0);
    chk("mrst_peak", peak_A, 0);
    chk("mrst_strobe", peak_strobe, 0);
    chk("mrst_state", dc_state, 0);
    run('h2000, 20);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
